mod6_count_monitor: RTL and testbench

//  Downstream consumer of the asynchronous mod-6 ripple counter output (Q[2:0]).

---
 rtl/mod6_mon_pkg.sv | 20 ++
 rtl/mod6_count_monitor_filter.sv | 64 ++++++
 rtl/mod6_count_monitor.sv | 122 ++++++++++++
 tb/tb_mod6_count_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod6_mon_pkg.sv
// Shared constants, FSM state type and code helpers for the mod-6 ripple counter monitor.
package mod6_mon_pkg;

    localparam int MOD_N  = 6;
    localparam int CODE_W = 3;

    typedef enum logic {
        S_INIT,
        S_TRACK
    } state_t;

    function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] c);
        return (c == CODE_W'(MOD_N - 1)) ? '0 : c + 1'b1;
    endfunction

    function automatic logic is_legal(input logic [CODE_W-1:0] c);
        return c < CODE_W'(MOD_N);
    endfunction

endpackage

// File: rtl/mod6_count_monitor_filter.sv
// Two-flop synchroniser for the ripple code plus a run-length filter that
// declares a code stable once it has been seen STABLE_CYCLES times in a row.
module sync_stable_filter
    import mod6_mon_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [CODE_W-1:0] q_in,
    output logic [CODE_W-1:0] stable_code,
    output logic              stable
);

    localparam int              RUN_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    logic [CODE_W-1:0] q_meta;
    logic [CODE_W-1:0] qs;
    logic [CODE_W-1:0] run_code;
    logic [RUN_W-1:0]  run;
    logic [RUN_W-1:0]  run_now;
    logic [1:0]        fill;
    logic              primed;

    // The cleared sync flops hold a fake code 0 after reset; ignore them until refilled.
    assign primed = fill[1];

    // Run length including the sample currently at the synchroniser output.
    always_comb begin
        run_now = '0;
        if (primed) begin
            if (qs != run_code) begin
                run_now = RUN_W'(1);
            end else if (run != RUN_MAX) begin
                run_now = run + 1'b1;
            end else begin
                run_now = RUN_MAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            q_meta   <= '0;
            qs       <= '0;
            run_code <= '0;
            run      <= '0;
            fill     <= '0;
        end else begin
            q_meta <= q_in;
            qs     <= q_meta;
            fill   <= {fill[0], 1'b1};
            run    <= run_now;
            if (primed) begin
                run_code <= qs;
            end
        end
    end

    assign stable_code = qs;
    assign stable      = (run_now == RUN_MAX);

endmodule

// File: rtl/mod6_count_monitor.sv
// Mod-6 ripple counter monitor: filters the async code, tracks 0..5 and flags errors.
// Optional irq_mask/irq ports are enabled by defining MOD6_MON_IRQ_EN.
module mod6_count_monitor
    import mod6_mon_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,
    parameter int WRAP_W        = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [CODE_W-1:0] q_in,
    input  logic              err_clear,
    output logic              valid_out,
    output logic [CODE_W-1:0] count_out,
    output logic [MOD_N-1:0]  onehot_out,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              illegal_err,
    output logic              seq_err
`ifdef MOD6_MON_IRQ_EN
    ,
    input  logic [1:0]        irq_mask,
    output logic              irq
`endif
);

    logic [CODE_W-1:0] stable_code;
    logic              stable;
    logic              accept;

    state_t            state;
    state_t            state_n;
    logic              valid_n;
    logic [CODE_W-1:0] count_n;
    logic              wrap_n;
    logic              seq_set;
    logic              illegal_set;
    logic              seq_n;
    logic              illegal_n;

    sync_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk        (clk),
        .clr        (clr),
        .q_in       (q_in),
        .stable_code(stable_code),
        .stable     (stable)
    );

    assign accept = stable && is_legal(stable_code);

    // Set events take priority over err_clear so a coincident error is never lost.
    always_comb begin
        state_n     = state;
        valid_n     = valid_out;
        count_n     = count_out;
        wrap_n      = 1'b0;
        seq_set     = 1'b0;
        illegal_set = stable && !is_legal(stable_code);

        case (state)
            S_INIT: begin
                if (accept) begin
                    count_n = stable_code;
                    valid_n = 1'b1;
                    state_n = S_TRACK;
                end
            end
            S_TRACK: begin
                if (accept && (stable_code != count_out)) begin
                    count_n = stable_code;
                    if (stable_code != next_code(count_out)) begin
                        seq_set = 1'b1;
                    end
                    if ((count_out == CODE_W'(MOD_N - 1)) && (stable_code == '0)) begin
                        wrap_n = 1'b1;
                    end
                end
            end
            default: state_n = S_INIT;
        endcase

        illegal_n = illegal_set | (illegal_err & ~err_clear);
        seq_n     = seq_set | (seq_err & ~err_clear);
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state       <= S_INIT;
            valid_out   <= 1'b0;
            count_out   <= '0;
            wrap_pulse  <= 1'b0;
            wrap_count  <= '0;
            illegal_err <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state       <= state_n;
            valid_out   <= valid_n;
            count_out   <= count_n;
            wrap_pulse  <= wrap_n;
            illegal_err <= illegal_n;
            seq_err     <= seq_n;
            if (wrap_n) begin
                wrap_count <= wrap_count + 1'b1;
            end
        end
    end

    assign onehot_out = valid_out ? (MOD_N'(1) << count_out) : '0;

`ifdef MOD6_MON_IRQ_EN
    always_ff @(posedge clk) begin
        if (!clr) begin
            irq <= 1'b0;
        end else begin
            irq <= (illegal_err & ~irq_mask[0]) | (seq_err & ~irq_mask[1]);
        end
    end
`endif

endmodule

// File: tb/tb_mod6_count_monitor.sv
// Randomised and directed bench for mod6_count_monitor against a sample-history reference model.
module tb_mod6_count_monitor;

    localparam int STABLE = 2;
    localparam int WW     = 2;

    logic       clk       = 1'b0;
    logic       clr       = 1'b0;
    logic       err_clear = 1'b0;
    logic [2:0] q_in      = 3'd0;

    logic          valid_out;
    logic [2:0]    count_out;
    logic [5:0]    onehot_out;
    logic          wrap_pulse;
    logic [WW-1:0] wrap_count;
    logic          illegal_err;
    logic          seq_err;
`ifdef MOD6_MON_IRQ_EN
    logic [1:0]    irq_mask = 2'b00;
    logic          irq;
`endif

    always #5 clk = ~clk;

    mod6_count_monitor #(
        .STABLE_CYCLES(STABLE),
        .WRAP_W       (WW)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .q_in       (q_in),
        .err_clear  (err_clear),
        .valid_out  (valid_out),
        .count_out  (count_out),
        .onehot_out (onehot_out),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .illegal_err(illegal_err),
        .seq_err    (seq_err)
`ifdef MOD6_MON_IRQ_EN
        ,
        .irq_mask   (irq_mask),
        .irq        (irq)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: q_in samples since the last reset release.
    int hist[$];
    int nsamp     = 0;
    int m_valid   = 0;
    int m_count   = 0;
    int m_illegal = 0;
    int m_seq     = 0;
    int m_wp      = 0;
    int m_wc      = 0;
    int m_irq     = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // A code is accepted when the last STABLE samples, seen through two sync stages, agree.
    task automatic modelEdge();
        int c;
        bit st;
        int irq_n;
        irq_n = 0;
`ifdef MOD6_MON_IRQ_EN
        irq_n = ((m_illegal != 0 && !irq_mask[0]) || (m_seq != 0 && !irq_mask[1])) ? 1 : 0;
`endif
        if (!clr) begin
            hist.delete();
            nsamp = 0; m_valid = 0; m_count = 0; m_illegal = 0;
            m_seq = 0; m_wp = 0; m_wc = 0; m_irq = 0;
            return;
        end
        m_irq = irq_n;
        hist.push_back(int'(q_in));
        nsamp++;
        if (hist.size() > 8) void'(hist.pop_front());
        m_wp = 0;
        st = 0;
        c = 0;
        if (nsamp >= STABLE + 2) begin
            c  = hist[hist.size() - 3];
            st = 1;
            for (int j = 1; j < STABLE; j++)
                if (hist[hist.size() - 3 - j] != c) st = 0;
        end
        if (err_clear) begin
            m_illegal = 0;
            m_seq = 0;
        end
        if (st) begin
            if (c >= 6) begin
                m_illegal = 1;
            end else if (m_valid == 0) begin
                m_valid = 1;
                m_count = c;
            end else if (c != m_count) begin
                if (c != (m_count + 1) % 6) m_seq = 1;
                if (m_count == 5 && c == 0) begin
                    m_wp = 1;
                    m_wc = (m_wc + 1) % (1 << WW);
                end
                m_count = c;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("valid_out",   valid_out,   m_valid);
        checkOutput("count_out",   count_out,   m_count);
        checkOutput("onehot_out",  onehot_out,  (m_valid != 0) ? (1 << m_count) : 0);
        checkOutput("wrap_pulse",  wrap_pulse,  m_wp);
        checkOutput("wrap_count",  wrap_count,  m_wc);
        checkOutput("illegal_err", illegal_err, m_illegal);
        checkOutput("seq_err",     seq_err,     m_seq);
`ifdef MOD6_MON_IRQ_EN
        checkOutput("irq",         irq,         m_irq);
`endif
    endtask

    task automatic applyStimulus(input int q, input int cycles, input bit errc = 1'b0, input bit rst_n = 1'b1);
        repeat (cycles) begin
            @(negedge clk);
            q_in      = q[2:0];
            err_clear = errc;
            clr       = rst_n;
            @(posedge clk);
            modelEdge();
            #1;
            checkAll();
        end
    endtask

    initial begin
        // Reset held with code 3, then first acceptance after 2+STABLE cycles.
        applyStimulus(3, 3, 1'b0, 1'b0);
        checkOutput("rst_valid", valid_out, 0);
        checkOutput("rst_wrap_count", wrap_count, 0);
        applyStimulus(3, 3);
        checkOutput("init_not_yet", valid_out, 0);
        applyStimulus(3, 1);
        checkOutput("init_count", count_out, 3);
        checkOutput("init_onehot", onehot_out, 6'b001000);
        checkOutput("init_seq", seq_err, 0);

        // Clean 0..5,0 sequence.
        applyStimulus(0, 2, 1'b0, 1'b0);
        for (int v = 0; v < 6; v++) applyStimulus(v, 10);
        applyStimulus(0, 10);
        checkOutput("seq_wrap_count", wrap_count, 1);
        checkOutput("seq_no_seq_err", seq_err, 0);
        checkOutput("seq_no_illegal", illegal_err, 0);

        // Clear-glitch 6 for one cycle during 5->0 is filtered out.
        for (int v = 1; v < 6; v++) applyStimulus(v, 10);
        applyStimulus(6, 1);
        applyStimulus(0, 10);
        checkOutput("glitch_illegal", illegal_err, 0);
        checkOutput("glitch_wrap_count", wrap_count, 2);

        // Held 7 is illegal and never accepted.
        for (int v = 1; v < 6; v++) applyStimulus(v, 10);
        applyStimulus(7, 10);
        checkOutput("hold7_illegal", illegal_err, 1);
        checkOutput("hold7_count", count_out, 5);
        applyStimulus(0, 8);
        applyStimulus(0, 1, 1'b1);
        checkOutput("illegal_cleared", illegal_err, 0);

        // Skip 1->3, clear, then a skip coincident with err_clear.
        applyStimulus(1, 2, 1'b0, 1'b0);
        applyStimulus(1, 8);
        applyStimulus(3, 8);
        checkOutput("skip_seq_err", seq_err, 1);
        checkOutput("skip_count", count_out, 3);
        applyStimulus(3, 1, 1'b1);
        checkOutput("skip_cleared", seq_err, 0);
        applyStimulus(5, 3);
        applyStimulus(5, 1, 1'b1);
        applyStimulus(5, 4);
        checkOutput("skip_set_wins", seq_err, 1);
        checkOutput("skip2_count", count_out, 5);

        // Wrap counter overflow with a 2-bit counter: 1,2,3,0,1.
        applyStimulus(0, 2, 1'b0, 1'b0);
        applyStimulus(0, 6);
        for (int w = 1; w <= 5; w++) begin
            for (int v = 1; v < 6; v++) applyStimulus(v, 6);
            applyStimulus(0, 6);
            checkOutput("wrap_overflow", wrap_count, w % 4);
        end
        applyStimulus(2, 6);
        applyStimulus(2, 1, 1'b0, 1'b0);
        checkOutput("midclr_wrap", wrap_count, 0);
        checkOutput("midclr_valid", valid_out, 0);
        applyStimulus(2, 6);

`ifdef MOD6_MON_IRQ_EN
        // Seq errors masked, illegal codes unmasked.
        irq_mask = 2'b10;
        applyStimulus(1, 2, 1'b0, 1'b0);
        applyStimulus(1, 8);
        applyStimulus(3, 8);
        checkOutput("irq_masked_seq", irq, 0);
        applyStimulus(7, 8);
        checkOutput("irq_illegal", irq, 1);
`endif

        // Random holds, mostly following the count with skips, glitches and clears mixed in.
        applyStimulus(0, 2, 1'b0, 1'b0);
        for (int n = 0; n < 200; n++) begin
            int v;
            int dur;
            bit ec;
            bit rs;
            if ($urandom_range(0, 9) < 7) v = (m_count + 1) % 6;
            else v = $urandom_range(0, 7);
            dur = $urandom_range(1, 6);
            ec  = ($urandom_range(0, 7) == 0);
            rs  = ($urandom_range(0, 39) != 0);
`ifdef MOD6_MON_IRQ_EN
            irq_mask = 2'($urandom_range(0, 3));
`endif
            applyStimulus(v, 1, ec, rs);
            applyStimulus(v, dur - 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
